// File: rtl/serial_comparator.sv
// serial_comparator
//   Bit-serial magnitude comparator. Operands are consumed LSB-first, one bit
//   per clock, through a single less/equal/greater cascade cell whose state is
//   registered between cycles. A result is produced WIDTH cycles after the
//   accepting edge.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; results hold the last completed compare
//   SHIFT  | one operand bit per edge folded into the cascade registers
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset
//   start                compare request, sampled only in IDLE
//   a, b                 operands, sampled on the accepting edge
//   cas_l, cas_e, cas_g  initial cascade from a less-significant stage
//   busy                 compare in progress
//   done                 one-cycle pulse on the edge that updates lt/eq/gt
//   lt, eq, gt           registered result of the last completed compare

module serial_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cas_l,
   input  logic             cas_e,
   input  logic             cas_g,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   logic             state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [CW-1:0]    cnt;
   logic             cl;
   logic             ce;
   logic             cg;

   logic x_bit;
   logic y_bit;
   logic q_bit;
   logic cl_nxt;
   logic ce_nxt;
   logic cg_nxt;

   // One comparator cell: a differing bit overrides the lower-order decision,
   // equal bits pass it through unchanged.
   always_comb begin
      x_bit  = sa[0];
      y_bit  = sb[0];
      q_bit  = ~(x_bit ^ y_bit);
      ce_nxt = ce & q_bit;
      cl_nxt = (cl & q_bit) | (~x_bit & y_bit);
      cg_nxt = (cg & q_bit) | (x_bit & ~y_bit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         lt    <= 1'b0;
         eq    <= 1'b0;
         gt    <= 1'b0;
         cl    <= 1'b0;
         ce    <= 1'b0;
         cg    <= 1'b0;
         cnt   <= '0;
         sa    <= '0;
         sb    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  cl    <= cas_l;
                  ce    <= cas_e;
                  cg    <= cas_g;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               cl <= cl_nxt;
               ce <= ce_nxt;
               cg <= cg_nxt;
               sa <= sa >> 1;
               sb <= sb >> 1;
               if (cnt == LAST) begin
                  // Last bit: publish the cascade as the result. cnt is left
                  // at LAST so it never wraps; it is reloaded on the next accept.
                  lt    <= cl_nxt;
                  eq    <= ce_nxt;
                  gt    <= cg_nxt;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
